uart_receiver: RTL

//  Serial-to-parallel UART receive path, the counterpart of the UART transmitter.
//  - Oversamples the serial line on the baud x16 tick from the baud generator.
//  - Deframes start/data/parity/stop bits and reports the byte plus PE/FE/BI status.
//  - Feeds RBR/LSR logic; in loopback mode it receives the transmitter's loop_txd.

---
 rtl/uart_receiver_if.sv | 13 +
 rtl/uart_receiver.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/uart_receiver_if.sv
// Receive-path result bundle: the deframed byte, its status flags and the busy indication.
// The receiver drives it (master); RBR/LSR logic consumes it (slave).
interface uart_receiver_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       pe;
  logic       fe;
  logic       bi;
  logic       rx_busy;

  modport master (output rx_data, rx_valid, pe, fe, bi, rx_busy);
  modport slave  (input  rx_data, rx_valid, pe, fe, bi, rx_busy);
endinterface

// File: rtl/uart_receiver.sv
// UART receive path: oversampled start/data/parity/stop deframing with PE/FE/BI status.
// Define UART_RX_MAJORITY_EN for 2-of-3 majority bit sampling around the bit centre.
module uart_receiver #(
  parameter int OVERSAMPLE  = 16,
  parameter int SYNC_STAGES = 2
) (
  input  logic       pclk,
  input  logic       presetn,
  input  logic       urrst,
  input  logic       rx_edge,
  input  logic       uart_rxd,
  input  logic       loop,
  input  logic       loop_txd,
  input  logic [1:0] wls,
  input  logic       pen,
  input  logic       eps,
  input  logic       sp,
  uart_receiver_if.master rx
);

  localparam int CW = $clog2(OVERSAMPLE);
  localparam logic [CW-1:0] MID_CNT = CW'(OVERSAMPLE / 2 - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PARITY,
    STOP,
    BREAK_WAIT
  } state_t;

  // Input synchronizer; idles high so reset never looks like a start bit.
  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      logic stage_reg;
      if (gi == 0) begin : g_first
        always_ff @(posedge pclk or negedge presetn) begin
          if (!presetn) stage_reg <= 1'b1;
          else          stage_reg <= uart_rxd;
        end
      end else begin : g_rest
        always_ff @(posedge pclk or negedge presetn) begin
          if (!presetn) stage_reg <= 1'b1;
          else          stage_reg <= g_sync[gi-1].stage_reg;
        end
      end
    end
  endgenerate

  logic rxd_sync;
  logic line;
  logic bit_val;
  assign rxd_sync = g_sync[SYNC_STAGES-1].stage_reg;
  assign line     = loop ? loop_txd : rxd_sync;

  state_t          state_reg;
  logic [CW-1:0]   cnt_reg;

`ifdef UART_RX_MAJORITY_EN
  localparam logic [CW-1:0] EARLY_CNT = CW'(OVERSAMPLE / 2 - 2);
  localparam logic [CW-1:0] DEC_CNT   = CW'(OVERSAMPLE / 2);
  logic s_early_reg;
  logic s_mid_reg;

  // Samples one tick before and at the centre; the third vote is the live line.
  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      s_early_reg <= 1'b0;
      s_mid_reg   <= 1'b0;
    end else if (urrst) begin
      s_early_reg <= 1'b0;
      s_mid_reg   <= 1'b0;
    end else if (rx_edge && state_reg != IDLE) begin
      if (cnt_reg == EARLY_CNT) s_early_reg <= line;
      if (cnt_reg == MID_CNT)   s_mid_reg   <= line;
    end
  end

  assign bit_val = (s_early_reg & s_mid_reg) | (s_early_reg & line) | (s_mid_reg & line);
`else
  localparam logic [CW-1:0] DEC_CNT = MID_CNT;
  assign bit_val = line;
`endif

  logic [7:0] shift_reg;
  logic [2:0] bit_idx_reg;
  logic [1:0] wls_l_reg;
  logic       pen_l_reg;
  logic       eps_l_reg;
  logic       sp_l_reg;
  logic       par_bit_reg;
  logic       pe_pend_reg;
  logic [7:0] rx_data_reg;
  logic       rx_valid_reg;
  logic       pe_reg;
  logic       fe_reg;
  logic       bi_reg;
  logic       busy_reg;

  logic decide;
  logic brk;
  assign decide = (cnt_reg == DEC_CNT);
  assign brk    = (shift_reg == 8'h00) && (!pen_l_reg || !par_bit_reg) && !bit_val;

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      wls_l_reg    <= '0;
      pen_l_reg    <= 1'b0;
      eps_l_reg    <= 1'b0;
      sp_l_reg     <= 1'b0;
      par_bit_reg  <= 1'b0;
      pe_pend_reg  <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      pe_reg       <= 1'b0;
      fe_reg       <= 1'b0;
      bi_reg       <= 1'b0;
      busy_reg     <= 1'b0;
    end else if (urrst) begin
      state_reg    <= IDLE;
      cnt_reg      <= '0;
      shift_reg    <= '0;
      bit_idx_reg  <= '0;
      wls_l_reg    <= '0;
      pen_l_reg    <= 1'b0;
      eps_l_reg    <= 1'b0;
      sp_l_reg     <= 1'b0;
      par_bit_reg  <= 1'b0;
      pe_pend_reg  <= 1'b0;
      rx_data_reg  <= '0;
      rx_valid_reg <= 1'b0;
      pe_reg       <= 1'b0;
      fe_reg       <= 1'b0;
      bi_reg       <= 1'b0;
      busy_reg     <= 1'b0;
    end else begin
      rx_valid_reg <= 1'b0;
      if (rx_edge) begin
        cnt_reg <= cnt_reg + 1'b1;
        case (state_reg)
          IDLE: begin
            cnt_reg <= '0;
            if (!line) begin
              state_reg   <= START;
              busy_reg    <= 1'b1;
              wls_l_reg   <= wls;
              pen_l_reg   <= pen;
              eps_l_reg   <= eps;
              sp_l_reg    <= sp;
              shift_reg   <= '0;
              bit_idx_reg <= '0;
              par_bit_reg <= 1'b0;
              pe_pend_reg <= 1'b0;
            end
          end
          START: begin
            if (decide) begin
              if (bit_val) begin
                state_reg <= IDLE;
                busy_reg  <= 1'b0;
              end else begin
                state_reg <= DATA;
              end
            end
          end
          DATA: begin
            if (decide) begin
              shift_reg[bit_idx_reg] <= bit_val;
              bit_idx_reg            <= bit_idx_reg + 1'b1;
              if (bit_idx_reg == 3'd4 + {1'b0, wls_l_reg})
                state_reg <= pen_l_reg ? PARITY : STOP;
            end
          end
          PARITY: begin
            if (decide) begin
              par_bit_reg <= bit_val;
              // {sp,eps}: odd, even, stick-1, stick-0
              case ({sp_l_reg, eps_l_reg})
                2'b00:   pe_pend_reg <= ~(^shift_reg ^ bit_val);
                2'b01:   pe_pend_reg <= ^shift_reg ^ bit_val;
                2'b10:   pe_pend_reg <= ~bit_val;
                default: pe_pend_reg <= bit_val;
              endcase
              state_reg <= STOP;
            end
          end
          STOP: begin
            if (decide) begin
              rx_valid_reg <= 1'b1;
              rx_data_reg  <= shift_reg;
              pe_reg       <= pen_l_reg & pe_pend_reg;
              fe_reg       <= ~bit_val;
              bi_reg       <= brk;
              state_reg    <= brk ? BREAK_WAIT : IDLE;
              busy_reg     <= brk;
            end
          end
          BREAK_WAIT: begin
            if (line) begin
              state_reg <= IDLE;
              busy_reg  <= 1'b0;
            end
          end
          default: begin
            state_reg <= IDLE;
            busy_reg  <= 1'b0;
          end
        endcase
      end
    end
  end

  assign rx.rx_data  = rx_data_reg;
  assign rx.rx_valid = rx_valid_reg;
  assign rx.pe       = pe_reg;
  assign rx.fe       = fe_reg;
  assign rx.bi       = bi_reg;
  assign rx.rx_busy  = busy_reg;

endmodule
